// File: rtl/uart_word_assembler.sv
// ---------------------------------------------------------------------------
// uart_word_assembler
//
// Purpose:
//   Sits on the receive side of the uart and packs incoming bytes into one
//   wide work word for the miner core. The default word is 44 bytes: a
//   32-byte midstate followed by the 12-byte block-header tail. The finished
//   word is offered with a valid/ack handshake. If the host stalls in the
//   middle of a frame for too long, the partial frame is thrown away so the
//   host can resynchronise on a fresh frame.
//
// Ports:
//   i_clk_50m      system clock, 50 MHz
//   i_rst_n        asynchronous active-low reset
//   i_rx_rdy       uart rdy, level, held high until cleared
//   i_rx_data      uart dout, stable while i_rx_rdy is high
//   o_rx_rdy_clr   uart rdy_clr, single-cycle pulse per consumed byte
//   o_word_out     assembled word, first byte received ends up in the MSBs
//   o_word_valid   o_word_out is complete, held until i_word_ack
//   i_word_ack     consumer accepts the word, only looked at while valid
//   o_byte_cnt     bytes collected in the current frame
//   o_overrun      sticky, a byte arrived while the word was unacknowledged
//   o_timeout_err  one-cycle pulse when a partial frame is discarded
// ---------------------------------------------------------------------------
module uart_word_assembler #(
    parameter int NBYTES      = 44,
    parameter int TIMEOUT_CYC = 500000,
    parameter int CNT_W       = 6
) (
    input  logic                  i_clk_50m,
    input  logic                  i_rst_n,
    input  logic                  i_rx_rdy,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_rdy_clr,
    output logic [NBYTES*8-1:0]   o_word_out,
    output logic                  o_word_valid,
    input  logic                  i_word_ack,
    output logic [CNT_W-1:0]      o_byte_cnt,
    output logic                  o_overrun,
    output logic                  o_timeout_err
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLR_WAIT = 2'd1;
    localparam logic [1:0] S_COLLECT  = 2'd2;
    localparam logic [1:0] S_FULL     = 2'd3;

    // The timeout counter only ever needs to reach TIMEOUT_CYC-1.
    localparam int              TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [NBYTES*8-1:0]  r_word;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_overrun;
    logic                 r_timeout_err;
    logic                 r_drop_wait;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    logic       w_capture;
    logic       w_ack;
    logic       w_drop;
    logic       w_timeout;
    logic [1:0] w_state_nxt;

    // A byte is taken whenever the uart has one and we are able to store it.
    assign w_capture = i_rx_rdy && ((r_state == S_IDLE) || (r_state == S_COLLECT));

    // Acknowledge only counts while the word is actually being offered.
    assign w_ack = (r_state == S_FULL) && i_word_ack;

    // A byte turning up while the word is unacknowledged is dropped, but only
    // once per uart byte; the drop-wait flag holds off until rdy falls. When
    // ack arrives in the same cycle the ack wins and the byte is left pending
    // so that IDLE picks it up as the first byte of the next frame.
    assign w_drop = (r_state == S_FULL) && i_rx_rdy && !r_drop_wait && !i_word_ack;

    // Inter-byte timeout fires on the idle cycle that finds the counter at
    // its last value; only a partial frame in COLLECT can time out.
    assign w_timeout = (r_state == S_COLLECT) && !i_rx_rdy && (r_to_cnt == TO_LAST);

    // The clear strobe is combinational so the uart drops rdy on the same
    // edge that consumes the byte. It is gated with reset so nothing is
    // acknowledged to the uart while the block is held in reset.
    assign o_rx_rdy_clr  = i_rst_n && (w_capture || w_drop);

    assign o_word_out    = r_word;
    assign o_word_valid  = (r_state == S_FULL);
    assign o_byte_cnt    = r_byte_cnt;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_CLR_WAIT;
                end
            end
            S_CLR_WAIT: begin
                // Waiting for rdy to fall guarantees one uart byte is never
                // captured twice; a stuck-high rdy parks us here for good.
                if (!i_rx_rdy) begin
                    w_state_nxt = (r_byte_cnt == CNT_FULL) ? S_FULL : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_capture) begin
                    w_state_nxt = S_CLR_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FULL: begin
                if (w_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Word shift register: new bytes enter at the bottom, so after NBYTES
    // captures the first byte of the frame sits in the top byte lane. The
    // word is deliberately left alone on timeout and on ack.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
        end else if (w_capture) begin
            r_word <= {r_word[NBYTES*8-9:0], i_rx_data};
        end
    end

    // -----------------------------------------------------------------------
    // Byte counter: counts captures, cleared when the frame is handed over
    // or abandoned.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_capture) begin
            r_byte_cnt <= r_byte_cnt + CNT_ONE;
        end else if (w_timeout || w_ack) begin
            r_byte_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Inter-byte timeout counter: runs only while a partial frame sits in
    // COLLECT with no byte pending, and restarts on every capture.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_COLLECT) || w_capture || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Timeout error pulse, registered so it is a clean one-cycle strobe.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
        end
    end

    // -----------------------------------------------------------------------
    // Overrun flag: set by a dropped byte and held until the consumer takes
    // the word, so it stays visible for the whole lifetime of that word.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_ack) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Drop-wait flag: after a dropped byte, ignore rdy until the uart has
    // lowered it, otherwise one byte would be dropped (and cleared) twice.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_wait <= 1'b0;
        end else if ((r_state != S_FULL) || w_ack) begin
            r_drop_wait <= 1'b0;
        end else if (w_drop) begin
            r_drop_wait <= 1'b1;
        end else if (!i_rx_rdy) begin
            r_drop_wait <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_word_assembler
//
// Drives two assemblers from a simple uart byte model: a 4-byte instance
// with a short timeout for the handshake, timeout, overrun and reset
// scenarios, and a default 44-byte instance for the full-width word.
// Expected words are queued when their bytes are sent; monitors pop and
// compare when a word becomes valid.
// ---------------------------------------------------------------------------
module tb_uart_word_assembler;

    logic          clk;
    logic          rstN;

    logic          rxRdyA;
    logic [7:0]    rxDataA;
    logic          clrA;
    logic [31:0]   wordA;
    logic          validA;
    logic          ackA;
    logic [2:0]    cntA;
    logic          ovrA;
    logic          toA;

    logic          rxRdyB;
    logic [7:0]    rxDataB;
    logic          clrB;
    logic [351:0]  wordB;
    logic          validB;
    logic          ackB;
    logic [5:0]    cntB;
    logic          ovrB;
    logic          toB;

    int            vecCount  = 0;
    int            missCount = 0;
    int            clrCountA = 0;
    int            toCountA  = 0;
    logic          prevValidA = 1'b0;
    logic          prevValidB = 1'b0;

    logic [31:0]   expQA[$];
    logic [351:0]  expQB[$];

    uart_word_assembler #(
        .NBYTES      (4),
        .TIMEOUT_CYC (100),
        .CNT_W       (3)
    ) dutA (
        .i_clk_50m     (clk),
        .i_rst_n       (rstN),
        .i_rx_rdy      (rxRdyA),
        .i_rx_data     (rxDataA),
        .o_rx_rdy_clr  (clrA),
        .o_word_out    (wordA),
        .o_word_valid  (validA),
        .i_word_ack    (ackA),
        .o_byte_cnt    (cntA),
        .o_overrun     (ovrA),
        .o_timeout_err (toA)
    );

    uart_word_assembler dutB (
        .i_clk_50m     (clk),
        .i_rst_n       (rstN),
        .i_rx_rdy      (rxRdyB),
        .i_rx_data     (rxDataB),
        .o_rx_rdy_clr  (clrB),
        .o_word_out    (wordB),
        .o_word_valid  (validB),
        .i_word_ack    (ackB),
        .o_byte_cnt    (cntB),
        .o_overrun     (ovrB),
        .o_timeout_err (toB)
    );

    // Free-running 100 MHz-period style clock; only relative timing matters.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count clear strobes and timeout pulses late in the low phase, where
    // both the registered and the combinational outputs have settled.
    always @(negedge clk) begin
        #3;
        if (clrA) clrCountA++;
        if (toA)  toCountA++;
    end

    // Monitor for the 4-byte instance: every rising word_valid consumes the
    // oldest expected word.
    always @(negedge clk) begin
        #3;
        if (validA && !prevValidA) begin
            vecCount++;
            if (expQA.size() == 0) begin
                missCount++;
                $display("[TB] FAIL wordA_unexpected actual=%h required=<none queued>", wordA);
            end else begin
                logic [31:0] e;
                e = expQA.pop_front();
                if (wordA !== e) begin
                    missCount++;
                    $display("[TB] FAIL wordA_scoreboard actual=%h required=%h", wordA, e);
                end
            end
        end
        prevValidA = validA;
    end

    // Monitor for the 44-byte instance.
    always @(negedge clk) begin
        #3;
        if (validB && !prevValidB) begin
            vecCount++;
            if (expQB.size() == 0) begin
                missCount++;
                $display("[TB] FAIL wordB_unexpected actual=%h required=<none queued>", wordB);
            end else begin
                logic [351:0] e;
                e = expQB.pop_front();
                if (wordB !== e) begin
                    missCount++;
                    $display("[TB] FAIL wordB_scoreboard actual=%h required=%h", wordB, e);
                end
            end
        end
        prevValidB = validB;
    end

    // Single comparison with pass/fail bookkeeping.
    task automatic checkOutput(input string name, input logic [351:0] act, input logic [351:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behaves like the uart: presents a byte, waits for rdy_clr, then drops
    // rdy one cycle later. sel=0 drives the 4-byte instance, sel=1 the other.
    task automatic applyStimulus(input int sel, input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (sel == 0) begin
            rxDataA = b;
            rxRdyA  = 1'b1;
        end else begin
            rxDataB = b;
            rxRdyB  = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            #1;
            if ((sel == 0) ? clrA : clrB) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL rdy_clr_timeout actual=no pulse required=pulse byte=%h", b);
        end
        @(negedge clk);
        if (sel == 0) rxRdyA = 1'b0;
        else          rxRdyB = 1'b0;
    endtask

    // Bounded wait for word_valid on the chosen instance.
    task automatic waitValid(input int sel);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if ((sel == 0) ? validA : validB) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL word_valid_timeout actual=0 required=1 sel=%0d", sel);
        end
    endtask

    // One-cycle acknowledge on the 4-byte instance.
    task automatic ackWordA();
        @(negedge clk);
        ackA = 1'b1;
        @(negedge clk);
        ackA = 1'b0;
        #1;
    endtask

    initial begin
        int c0;
        int t0;
        logic [351:0] expB;

        rstN    = 1'b0;
        rxRdyA  = 1'b0;
        rxDataA = 8'h00;
        ackA    = 1'b0;
        rxRdyB  = 1'b0;
        rxDataB = 8'h00;
        ackB    = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_validA",   {351'b0, validA}, 352'd0);
        checkOutput("rst_cntA",     {349'b0, cntA},   352'd0);
        checkOutput("rst_wordA",    {320'b0, wordA},  352'd0);
        checkOutput("rst_ovrA",     {351'b0, ovrA},   352'd0);
        checkOutput("rst_toA",      {351'b0, toA},    352'd0);
        checkOutput("rst_wordB",    wordB,            352'd0);
        checkOutput("rst_validB",   {351'b0, validB}, 352'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Ack while nothing is valid is ignored
        ackA = 1'b1;
        @(negedge clk);
        ackA = 1'b0;
        #1;
        checkOutput("stray_ack_cnt",   {349'b0, cntA},   352'd0);
        checkOutput("stray_ack_valid", {351'b0, validA}, 352'd0);

        // Test 1: four bytes form one word, four clear strobes
        c0 = clrCountA;
        expQA.push_back(32'h11223344);
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
        applyStimulus(0, 8'h44);
        waitValid(0);
        checkOutput("t1_clr_pulses", 352'(clrCountA - c0), 352'd4);
        checkOutput("t1_cnt",        {349'b0, cntA},       352'd4);
        checkOutput("t1_valid",      {351'b0, validA},     352'd1);
        ackWordA();
        checkOutput("t1_ack_valid",  {351'b0, validA},     352'd0);
        checkOutput("t1_ack_cnt",    {349'b0, cntA},       352'd0);

        // Test 3: partial frame times out, then a clean frame follows
        t0 = toCountA;
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        repeat (250) @(negedge clk);
        #1;
        checkOutput("t3_timeout_pulses", 352'(toCountA - t0), 352'd1);
        checkOutput("t3_cnt",            {349'b0, cntA},      352'd0);
        checkOutput("t3_valid",          {351'b0, validA},    352'd0);
        expQA.push_back(32'hA0A1A2A3);
        applyStimulus(0, 8'hA0);
        applyStimulus(0, 8'hA1);
        applyStimulus(0, 8'hA2);
        applyStimulus(0, 8'hA3);
        waitValid(0);
        ackWordA();

        // Test 4: byte arriving on an unacknowledged word is dropped
        expQA.push_back(32'hDEADBEEF);
        applyStimulus(0, 8'hDE);
        applyStimulus(0, 8'hAD);
        applyStimulus(0, 8'hBE);
        applyStimulus(0, 8'hEF);
        waitValid(0);
        c0 = clrCountA;
        applyStimulus(0, 8'h55);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t4_clr_pulses", 352'(clrCountA - c0), 352'd1);
        checkOutput("t4_overrun",    {351'b0, ovrA},       352'd1);
        checkOutput("t4_word_kept",  {320'b0, wordA},      {320'b0, 32'hDEADBEEF});
        checkOutput("t4_valid_held", {351'b0, validA},     352'd1);
        ackWordA();
        checkOutput("t4_ack_overrun", {351'b0, ovrA},      352'd0);

        // Test 5: ack and a new byte in the same cycle
        expQA.push_back(32'h01020304);
        expQA.push_back(32'h7778797A);
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        applyStimulus(0, 8'h03);
        applyStimulus(0, 8'h04);
        waitValid(0);
        @(negedge clk);
        rxDataA = 8'h77;
        rxRdyA  = 1'b1;
        ackA    = 1'b1;
        #1;
        checkOutput("t5_clr_while_ack", {351'b0, clrA}, 352'd0);
        @(negedge clk);
        ackA = 1'b0;
        #1;
        checkOutput("t5_idle_clr",   {351'b0, clrA},   352'd1);
        checkOutput("t5_idle_valid", {351'b0, validA}, 352'd0);
        @(negedge clk);
        rxRdyA = 1'b0;
        #1;
        checkOutput("t5_cnt",      {349'b0, cntA},       352'd1);
        checkOutput("t5_overrun",  {351'b0, ovrA},       352'd0);
        checkOutput("t5_low_byte", {344'b0, wordA[7:0]}, 352'h77);
        applyStimulus(0, 8'h78);
        applyStimulus(0, 8'h79);
        applyStimulus(0, 8'h7A);
        waitValid(0);
        ackWordA();

        // Test 6: reset in the middle of a frame
        applyStimulus(0, 8'hC1);
        applyStimulus(0, 8'hC2);
        applyStimulus(0, 8'hC3);
        @(negedge clk);
        rstN   = 1'b0;
        rxRdyA = 1'b1;
        #1;
        checkOutput("t6_rst_cnt",   {349'b0, cntA},   352'd0);
        checkOutput("t6_rst_word",  {320'b0, wordA},  352'd0);
        checkOutput("t6_rst_clr",   {351'b0, clrA},   352'd0);
        checkOutput("t6_rst_valid", {351'b0, validA}, 352'd0);
        @(negedge clk);
        rxRdyA = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        expQA.push_back(32'h5A6B7C8D);
        applyStimulus(0, 8'h5A);
        applyStimulus(0, 8'h6B);
        applyStimulus(0, 8'h7C);
        applyStimulus(0, 8'h8D);
        waitValid(0);
        checkOutput("t6_word", {320'b0, wordA}, {320'b0, 32'h5A6B7C8D});
        ackWordA();

        // Test 2: default 44-byte word, bytes 0x00..0x2B
        expB = '0;
        for (int i = 0; i < 44; i++) begin
            expB = {expB[343:0], 8'(i)};
        end
        expQB.push_back(expB);
        for (int i = 0; i < 44; i++) begin
            applyStimulus(1, 8'(i));
        end
        waitValid(1);
        checkOutput("t2_first_byte", {344'b0, wordB[351:344]}, 352'h00);
        checkOutput("t2_last_byte",  {344'b0, wordB[7:0]},     352'h2B);
        checkOutput("t2_cnt",        {346'b0, cntB},           352'd44);
        checkOutput("t2_overrun",    {351'b0, ovrB},           352'd0);

        // Every queued word must have been seen
        repeat (3) @(negedge clk);
        checkOutput("queueA_drained", 352'(expQA.size()), 352'd0);
        checkOutput("queueB_drained", 352'(expQB.size()), 352'd0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Consumer on the receive side of the uart block: reads bytes from its dout/rdy/rdy_clr interface and packs them into one wide work word for the miner core.
- Default word is 44 bytes: a 32-byte midstate followed by the 12-byte block-header tail.
- The word is presented with a valid/ack handshake.
- An inter-byte timeout discards partial frames so the host can resynchronise.

Parameters:
- NBYTES, 44, number of bytes per word (≥2).
- TIMEOUT_CYC, 500000, idle clk_50m cycles allowed between bytes of a partial frame (10 ms at 50 MHz).
- CNT_W, 6, width of byte_cnt; must satisfy 2^CNT_W > NBYTES.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_rdy  in  1  uart rdy; level, held high until cleared.
- rx_data  in  8  uart dout; stable while rx_rdy high.
- rx_rdy_clr  out  1  uart rdy_clr; single-cycle pulse.
- word_out  out  NBYTES*8  assembled word; first received byte in bits [NBYTES*8-1 -: 8].
- word_valid  out  1  word_out complete; held until word_ack.
- word_ack  in  1  consumer accepts word; sampled only while word_valid.
- byte_cnt  out  CNT_W  bytes collected in the current frame.
- overrun  out  1  sticky: a byte arrived while the word was unacknowledged.
- timeout_err  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0; word_out all zeros; state IDLE; timeout counter 0.
- Fully synchronous to clk_50m otherwise.
- States and transitions:
  - IDLE (byte_cnt=0): rx_rdy=1 -> capture byte, pulse rx_rdy_clr, go to CLR_WAIT.
  - CLR_WAIT: wait for rx_rdy=0, the uart's response to clr, so one byte is never captured twice. Then go to FULL if byte_cnt==NBYTES, else COLLECT.
  - COLLECT (0<byte_cnt<NBYTES): same capture rule as IDLE. The timeout counter increments each cycle with rx_rdy=0; at TIMEOUT_CYC-1: byte_cnt<=0, timeout_err pulses, go to IDLE. word_out is not cleared on timeout.
  - FULL: word_valid=1. word_ack=1 -> word_valid<=0, byte_cnt<=0, overrun<=0, go to IDLE.
- Capture: word_out <= {word_out[NBYTES*8-9:0], rx_data}; byte_cnt increments. rx_rdy_clr is high exactly in the capture cycle. First-byte-in reaches the MSB after NBYTES shifts.
- Capture-to-valid latency:
  - The final byte's capture edge sets byte_cnt=NBYTES.
  - word_valid rises on the edge after rx_rdy is seen low in CLR_WAIT.
- The timeout counter resets to 0 on every capture and in IDLE, CLR_WAIT and FULL. The timeout never fires in IDLE.
- Byte arriving in FULL (rx_rdy=1):
  - Dropped; word_out is unchanged.
  - rx_rdy_clr pulses once; overrun<=1.
  - Waits for rx_rdy=0 before honouring another arrival, via an internal drop-wait flag; remains in FULL.
- Simultaneous events in FULL, same cycle:
  - word_ack and rx_rdy: ack wins, go to IDLE, byte not cleared.
  - The still-high rx_rdy is captured in IDLE the next cycle as byte 0 of the new frame.
  - overrun is not set.
- word_ack while not word_valid: ignored.
- rx_rdy stuck high in CLR_WAIT: stay there indefinitely; no further rx_rdy_clr pulses.
- Reset mid-frame: partial frame lost, byte_cnt=0; rx_rdy_clr forced 0 during reset.

Test Plan:
1. NBYTES=4, uart loopback, send 0x11,0x22,0x33,0x44 -> word_valid=1, word_out=0x11223344, exactly 4 rx_rdy_clr pulses. Ack -> word_valid=0, byte_cnt=0.
2. Default NBYTES=44, send bytes 0x00..0x2B -> word_out[351:344]=0x00, word_out[7:0]=0x2B, byte_cnt=44, overrun=0.
3. TIMEOUT_CYC=100, send 2 bytes, idle 100 cycles -> one timeout_err pulse, byte_cnt=0. Then send 4 bytes 0xA0..0xA3 -> word_out=0xA0A1A2A3.
4. Word held unacked, send 0x55 -> rx_rdy_clr pulses once, overrun=1, word_out unchanged. Ack -> overrun=0.
5. Hold rx_rdy=1 with word_ack asserted the same cycle in FULL -> next cycle capture into byte 0, byte_cnt=1, overrun=0.
6. Assert rst_n=0 after 3 of 4 bytes -> all outputs 0 asynchronously. After release, 4 new bytes yield a correct word with no stale data.
